// File: rtl/prog_memory.sv
// Program memory with CPU/manual write ports and a burst loader.
// The loader FSM owns the array while busy; other writes are dropped then.
module prog_memory #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int READ_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus,
    input  logic              MI,
    input  logic              WE,
    input  logic              SEL,
    input  logic              manual_WE,
    input  logic [ADDR_W-1:0] manual_addr,
    input  logic [DATA_W-1:0] manual_value,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic [ADDR_W-1:0] mar_out,
    output logic [DATA_W-1:0] mem_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;

    assign accept = load_valid && load_ready;

    always_comb begin
        addr    = mar_out;
        wr_data = bus;
        wr_en   = WE;
        if (load_busy) begin
            addr    = ptr;
            wr_data = load_data;
            wr_en   = accept;
        end else if (SEL) begin
            addr    = manual_addr;
            wr_data = manual_value;
            wr_en   = manual_WE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mar_out <= '0;
        end else if (MI) begin
            mar_out <= bus[ADDR_W-1:0];
        end
    end

    // count is all-ones on the DEPTH-th beat, which forces termination
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            count      <= '0;
            load_ready <= 1'b0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state      <= LOAD;
                        ptr        <= load_base;
                        count      <= '0;
                        load_ready <= 1'b1;
                        load_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        ptr   <= ptr + 1'b1;
                        count <= count + 1'b1;
                        if (load_last || count == '1) begin
                            state      <= DONE;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    load_busy <= 1'b0;
                    load_done <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b0;
                    load_busy  <= 1'b0;
                    load_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    generate
        if (READ_REG != 0) begin : g_read_reg
            logic [DATA_W-1:0] rd_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= mem[addr];
                end
            end
            assign mem_out = rd_q;
        end else begin : g_read_comb
            assign mem_out = mem[addr];
        end
    endgenerate

endmodule

// File: tb/tb_prog_memory.sv
// Bench for prog_memory: combinational and registered-read instances share
// stimulus and are checked every cycle against a behavioural model.
module tb_prog_memory;

    logic       clk;
    logic       rst;
    logic [7:0] bus;
    logic       MI;
    logic       WE;
    logic       SEL;
    logic       manual_WE;
    logic [3:0] manual_addr;
    logic [7:0] manual_value;
    logic       load_start;
    logic [3:0] load_base;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;

    logic       load_ready,   load_ready_r;
    logic       load_busy,    load_busy_r;
    logic       load_done,    load_done_r;
    logic [3:0] mar_out,      mar_out_r;
    logic [7:0] mem_out,      mem_out_r;

    int checks = 0;
    int errors = 0;

    prog_memory #(.DATA_W(8), .ADDR_W(4), .READ_REG(0)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .MI(MI), .WE(WE), .SEL(SEL),
        .manual_WE(manual_WE), .manual_addr(manual_addr), .manual_value(manual_value),
        .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .load_busy(load_busy), .load_done(load_done), .mar_out(mar_out), .mem_out(mem_out)
    );

    prog_memory #(.DATA_W(8), .ADDR_W(4), .READ_REG(1)) u_dut_r (
        .clk(clk), .rst(rst), .bus(bus), .MI(MI), .WE(WE), .SEL(SEL),
        .manual_WE(manual_WE), .manual_addr(manual_addr), .manual_value(manual_value),
        .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready_r),
        .load_busy(load_busy_r), .load_done(load_done_r), .mar_out(mar_out_r), .mem_out(mem_out_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: 0 = idle, 1 = loading, 2 = done
    logic [7:0] m_mem [16];
    bit         m_known [16];
    int         m_state;
    int         m_ptr;
    int         m_cnt;
    int         m_mar;
    logic [7:0] m_rdq;
    bit         m_rdq_known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rd_addr();
        if (m_state != 0) return m_ptr;
        if (SEL) return int'(manual_addr);
        return m_mar;
    endfunction

    task automatic model_reset();
        m_state     = 0;
        m_ptr       = 0;
        m_cnt       = 0;
        m_mar       = 0;
        m_rdq       = 8'h00;
        m_rdq_known = 1'b1;
    endtask

    task automatic compare_outputs();
        int a;
        a = rd_addr();
        check("ready",   32'(load_ready),   32'(m_state == 1));
        check("busy",    32'(load_busy),    32'(m_state != 0));
        check("done",    32'(load_done),    32'(m_state == 2));
        check("mar",     32'(mar_out),      32'(m_mar));
        check("ready_r", 32'(load_ready_r), 32'(m_state == 1));
        check("busy_r",  32'(load_busy_r),  32'(m_state != 0));
        check("done_r",  32'(load_done_r),  32'(m_state == 2));
        check("mar_r",   32'(mar_out_r),    32'(m_mar));
        if (m_known[a]) check("mem_comb", 32'(mem_out), 32'(m_mem[a]));
        if (m_rdq_known) check("mem_reg", 32'(mem_out_r), 32'(m_rdq));
    endtask

    // Apply current inputs for one rising edge, advance the model, compare.
    task automatic step();
        int         a;
        bit         acc;
        bit         wr;
        logic [7:0] wd;
        a           = rd_addr();
        m_rdq       = m_mem[a];
        m_rdq_known = m_known[a];
        acc         = (m_state == 1) && load_valid;
        wr          = 1'b0;
        wd          = 8'h00;
        if (acc) begin
            wr = 1'b1;
            wd = load_data;
        end else if (m_state == 0) begin
            if (SEL && manual_WE) begin
                wr = 1'b1;
                wd = manual_value;
            end else if (!SEL && WE) begin
                wr = 1'b1;
                wd = bus;
            end
        end
        if (wr) begin
            m_mem[a]   = wd;
            m_known[a] = 1'b1;
        end
        if (MI) m_mar = int'(bus[3:0]);
        case (m_state)
            0: if (load_start) begin
                m_state = 1;
                m_ptr   = int'(load_base);
                m_cnt   = 0;
            end
            1: if (acc) begin
                m_ptr = (m_ptr + 1) % 16;
                m_cnt = m_cnt + 1;
                if (load_last || m_cnt == 16) m_state = 2;
            end
            default: m_state = 0;
        endcase
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic quiet();
        MI = 0; WE = 0; manual_WE = 0; load_start = 0; load_valid = 0; load_last = 0;
    endtask

    task automatic peek(input string tag, input int a, input logic [7:0] exp);
        quiet();
        SEL         = 1'b1;
        manual_addr = a[3:0];
        step();
        check(tag, 32'(mem_out), 32'(exp));
        check(tag, 32'(mem_out_r), 32'(exp));
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic start_burst(input logic [3:0] base);
        quiet();
        load_start = 1'b1;
        load_base  = base;
        step();
        load_start = 1'b0;
    endtask

    // Assert reset between edges; outputs must clear before any clock.
    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        bus = '0; SEL = 0; manual_addr = '0; manual_value = '0;
        load_base = '0; load_data = '0;
        quiet();
        #2;
        model_reset();
        compare_outputs();
        #1 rst = 1'b1;

        // Fill memory so every read is defined
        for (int i = 0; i < 16; i++) begin
            SEL          = 1'b1;
            manual_WE    = 1'b1;
            manual_addr  = 4'(i);
            manual_value = 8'($urandom);
            step();
        end
        quiet();

        // CPU path
        SEL = 1'b0; bus = 8'h08; MI = 1'b1;
        step();
        check("cpu_mar", 32'(mar_out), 32'h8);
        MI = 1'b0; bus = 8'h5A; WE = 1'b1;
        step();
        check("cpu_mem", 32'(mem_out), 32'h5A);
        peek("cpu_peek8", 8, 8'h5A);

        // Manual override with WE also high
        SEL = 1'b1; manual_addr = 4'd3; manual_value = 8'hC3; manual_WE = 1'b1; WE = 1'b1;
        step();
        peek("man_peek3", 3, 8'hC3);
        peek("man_peek8", 8, 8'h5A);

        // Burst with pointer wrap
        start_burst(4'd14);
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b1);
        check("wrap_done", 32'(load_done), 32'h1);
        quiet();
        step();
        check("wrap_done_end", 32'(load_done), 32'h0);
        check("wrap_busy_end", 32'(load_busy), 32'h0);
        peek("wrap14", 14, 8'h11);
        peek("wrap15", 15, 8'h22);
        peek("wrap0", 0, 8'h33);

        // Backpressure gaps and bus-write lockout
        start_burst(4'd2);
        SEL = 1'b0; WE = 1'b1; bus = 8'hEE;
        beat(8'hAA, 1'b0);
        step();
        check("gap_ready", 32'(load_ready), 32'h1);
        beat(8'hBB, 1'b0);
        step();
        step();
        beat(8'hCC, 1'b1);
        WE = 1'b0;
        step();
        peek("bp2", 2, 8'hAA);
        peek("bp3", 3, 8'hBB);
        peek("bp4", 4, 8'hCC);
        peek("bp8", 8, 8'h5A);

        // Full-depth burst without load_last
        start_burst(4'd5);
        for (int i = 0; i < 16; i++) beat(8'(8'h80 + i), 1'b0);
        check("full_done", 32'(load_done), 32'h1);
        quiet();
        step();
        for (int i = 0; i < 16; i++) peek("full_word", (5 + i) % 16, 8'(8'h80 + i));

        // Reset mid-burst
        start_burst(4'd9);
        beat(8'h61, 1'b0);
        beat(8'h62, 1'b0);
        load_valid = 1'b1;
        load_data  = 8'h63;
        async_reset();
        check("mrst_busy", 32'(load_busy), 32'h0);
        check("mrst_ready", 32'(load_ready), 32'h0);
        check("mrst_memr", 32'(mem_out_r), 32'h0);
        peek("mrst9", 9, 8'h61);
        peek("mrst10", 10, 8'h62);
        start_burst(4'd0);
        check("mrst_restart", 32'(load_busy), 32'h1);
        beat(8'h01, 1'b1);
        quiet();
        step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            SEL          = 1'($urandom_range(0, 1));
            WE           = 1'($urandom_range(0, 1));
            manual_WE    = 1'($urandom_range(0, 1));
            MI           = ($urandom_range(0, 3) == 0);
            bus          = 8'($urandom);
            manual_addr  = 4'($urandom);
            manual_value = 8'($urandom);
            load_start   = ($urandom_range(0, 7) == 0);
            load_base    = 4'($urandom);
            load_valid   = 1'($urandom_range(0, 1));
            load_data    = 8'($urandom);
            load_last    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) async_reset();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
